// File: rtl/mem_bus_pkg.sv
// Shared types, size codes and default address map for the memory bus arbiter.
// Also holds the read-data size mask applied when a read completes.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [31:0] DEF_ROM_LIMIT = 32'h0000_0400;
  localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_1000;
  localparam logic [31:0] DEF_RAM_LIMIT = 32'h0000_2000;
  localparam logic [31:0] DEF_IO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] DEF_IO_LIMIT  = 32'hFFFF_0100;

  function automatic logic [63:0] size_mask(input logic [1:0] size, input logic [63:0] data);
    logic [63:0] res;
    case (size)
      SZ_B:    res = {56'd0, data[7:0]};
      SZ_H:    res = {48'd0, data[15:0]};
      SZ_W:    res = {32'd0, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address map decode: one-hot region select plus an error flag
// for unmapped addresses and writes into ROM. All ranges are half-open.
module mem_addr_decode
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] ROM_LIMIT = DEF_ROM_LIMIT,
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] RAM_LIMIT = DEF_RAM_LIMIT,
  parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
  parameter logic [31:0] IO_LIMIT  = DEF_IO_LIMIT
) (
  input  logic [31:0] addr,
  input  logic        we,
  output logic        rom_sel,
  output logic        ram_sel,
  output logic        io_sel,
  output logic        err
);

  logic in_rom;
  logic in_ram;
  logic in_io;

  always_comb begin
    in_rom  = (addr < ROM_LIMIT);
    in_ram  = (addr >= RAM_BASE) && (addr < RAM_LIMIT);
    in_io   = (addr >= IO_BASE) && (addr < IO_LIMIT);
    err     = ~(in_rom | in_ram | in_io) | (in_rom & we);
    // An erroring access must never raise a select.
    rom_sel = in_rom & ~err;
    ram_sel = in_ram & ~err;
    io_sel  = in_io & ~err;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the shared memory bus.
// IDLE grants, ACCESS holds select/strobe for WAIT_CYC cycles, DONE pulses ack.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          WAIT_CYC  = 1,
  parameter logic [31:0] ROM_LIMIT = DEF_ROM_LIMIT,
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] RAM_LIMIT = DEF_RAM_LIMIT,
  parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
  parameter logic [31:0] IO_LIMIT  = DEF_IO_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [63:0] m0_wdata,
  output logic        m0_ack,
  output logic [63:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [63:0] m1_wdata,
  output logic        m1_ack,
  output logic [63:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_address,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  mem_size,
  output logic        mem_read,
  output logic        mem_write_en,
  output logic        ROM_select,
  output logic        RAM_select,
  output logic        IO_select
);

  generate
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
      $error("mem_bus_arbiter: WAIT_CYC must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_en_q, mem_write_en_d;
  logic        rom_sel_q, rom_sel_d;
  logic        ram_sel_q, ram_sel_d;
  logic        io_sel_q, io_sel_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;
  logic [63:0] m0_rdata_q, m0_rdata_d;
  logic [63:0] m1_rdata_q, m1_rdata_d;

  logic        pick;
  logic [31:0] req_addr;
  logic        req_we;
  logic        dec_rom, dec_ram, dec_io, dec_err;

  // On a tie the master that did not win last time goes next.
  assign pick     = (m0_req & m1_req) ? ~last_grant_q : m1_req;
  assign req_addr = pick ? m1_addr : m0_addr;
  assign req_we   = pick ? m1_we : m0_we;

  // Decode sees exactly the address being latched, so the error path can
  // skip ACCESS and ack one cycle after the grant.
  mem_addr_decode #(
    .ROM_LIMIT(ROM_LIMIT),
    .RAM_BASE (RAM_BASE),
    .RAM_LIMIT(RAM_LIMIT),
    .IO_BASE  (IO_BASE),
    .IO_LIMIT (IO_LIMIT)
  ) u_decode (
    .addr   (req_addr),
    .we     (req_we),
    .rom_sel(dec_rom),
    .ram_sel(dec_ram),
    .io_sel (dec_io),
    .err    (dec_err)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    gnt_d          = gnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_address_d  = mem_address_q;
    mem_wdata_d    = mem_wdata_q;
    mem_size_d     = mem_size_q;
    mem_read_d     = mem_read_q;
    mem_write_en_d = mem_write_en_q;
    rom_sel_d      = rom_sel_q;
    ram_sel_d      = ram_sel_q;
    io_sel_d       = io_sel_q;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    m0_ack_d       = 1'b0;
    m1_ack_d       = 1'b0;
    m0_err_d       = 1'b0;
    m1_err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          gnt_d         = pick;
          last_grant_d  = pick;
          mem_address_d = req_addr;
          mem_wdata_d   = pick ? m1_wdata : m0_wdata;
          mem_size_d    = pick ? m1_size : m0_size;
          wait_cnt_d    = WAIT_INIT;
          if (dec_err) begin
            state_d  = DONE;
            m0_ack_d = ~pick;
            m1_ack_d = pick;
            m0_err_d = ~pick;
            m1_err_d = pick;
          end else begin
            state_d        = ACCESS;
            rom_sel_d      = dec_rom;
            ram_sel_d      = dec_ram;
            io_sel_d       = dec_io;
            mem_read_d     = ~req_we;
            mem_write_en_d = req_we;
          end
        end
      end
      ACCESS: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d        = DONE;
          rom_sel_d      = 1'b0;
          ram_sel_d      = 1'b0;
          io_sel_d       = 1'b0;
          mem_read_d     = 1'b0;
          mem_write_en_d = 1'b0;
          m0_ack_d       = ~gnt_q;
          m1_ack_d       = gnt_q;
          if (!mem_write_en_q) begin
            if (gnt_q) m1_rdata_d = size_mask(mem_size_q, mem_rdata);
            else       m0_rdata_d = size_mask(mem_size_q, mem_rdata);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      gnt_q          <= 1'b0;
      wait_cnt_q     <= 4'd0;
      mem_address_q  <= 32'd0;
      mem_wdata_q    <= 64'd0;
      mem_size_q     <= 2'd0;
      mem_read_q     <= 1'b0;
      mem_write_en_q <= 1'b0;
      rom_sel_q      <= 1'b0;
      ram_sel_q      <= 1'b0;
      io_sel_q       <= 1'b0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m0_err_q       <= 1'b0;
      m1_err_q       <= 1'b0;
      m0_rdata_q     <= 64'd0;
      m1_rdata_q     <= 64'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      gnt_q          <= gnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_address_q  <= mem_address_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_size_q     <= mem_size_d;
      mem_read_q     <= mem_read_d;
      mem_write_en_q <= mem_write_en_d;
      rom_sel_q      <= rom_sel_d;
      ram_sel_q      <= ram_sel_d;
      io_sel_q       <= io_sel_d;
      m0_ack_q       <= m0_ack_d;
      m1_ack_q       <= m1_ack_d;
      m0_err_q       <= m0_err_d;
      m1_err_q       <= m1_err_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
    end
  end

  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign m0_err       = m0_err_q;
  assign m1_err       = m1_err_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign mem_address  = mem_address_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_size     = mem_size_q;
  assign mem_read     = mem_read_q;
  assign mem_write_en = mem_write_en_q;
  assign ROM_select   = rom_sel_q;
  assign RAM_select   = ram_sel_q;
  assign IO_select    = io_sel_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized run checked against a transaction-timing reference model.
module tb_mem_bus_arbiter;

  localparam int          W_A       = 1;
  localparam int          W_B       = 3;
  localparam logic [31:0] ROM_LIMIT = 32'h0000_0400;
  localparam logic [31:0] RAM_BASE  = 32'h0000_1000;
  localparam logic [31:0] RAM_LIMIT = 32'h0000_2000;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] IO_LIMIT  = 32'hFFFF_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata, mem_rdata;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic [63:0] a_m0_rdata, a_m1_rdata, a_mem_wdata;
  logic [31:0] a_mem_address;
  logic [1:0]  a_mem_size;
  logic        a_mem_read, a_mem_write_en, a_rom, a_ram, a_io;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [63:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [31:0] b_mem_address;
  logic [1:0]  b_mem_size;
  logic        b_mem_read, b_mem_write_en, b_rom, b_ram, b_io;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.WAIT_CYC(W_A)) dut_a (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
    .mem_address(a_mem_address), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
    .mem_size(a_mem_size), .mem_read(a_mem_read), .mem_write_en(a_mem_write_en),
    .ROM_select(a_rom), .RAM_select(a_ram), .IO_select(a_io)
  );

  mem_bus_arbiter #(.WAIT_CYC(W_B)) dut_b (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
    .mem_address(b_mem_address), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
    .mem_size(b_mem_size), .mem_read(b_mem_read), .mem_write_en(b_mem_write_en),
    .ROM_select(b_rom), .RAM_select(b_ram), .IO_select(b_io)
  );

  logic a_nz, b_nz;
  assign a_nz = |{a_m0_ack, a_m0_err, a_m0_rdata, a_m1_ack, a_m1_err, a_m1_rdata, a_mem_address,
                  a_mem_wdata, a_mem_size, a_mem_read, a_mem_write_en, a_rom, a_ram, a_io};
  assign b_nz = |{b_m0_ack, b_m0_err, b_m0_rdata, b_m1_ack, b_m1_err, b_m1_rdata, b_mem_address,
                  b_mem_wdata, b_mem_size, b_mem_read, b_mem_write_en, b_rom, b_ram, b_io};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Output views of either DUT (b=0: WAIT_CYC=1 instance, b=1: WAIT_CYC=3 instance).
  function automatic logic ack_of(input bit b, input bit m);
    return b ? (m ? b_m1_ack : b_m0_ack) : (m ? a_m1_ack : a_m0_ack);
  endfunction
  function automatic logic err_of(input bit b, input bit m);
    return b ? (m ? b_m1_err : b_m0_err) : (m ? a_m1_err : a_m0_err);
  endfunction
  function automatic logic [63:0] rdata_of(input bit b, input bit m);
    return b ? (m ? b_m1_rdata : b_m0_rdata) : (m ? a_m1_rdata : a_m0_rdata);
  endfunction
  function automatic logic [2:0] sel_of(input bit b);
    return b ? {b_rom, b_ram, b_io} : {a_rom, a_ram, a_io};
  endfunction

  function automatic logic [63:0] ref_mask(input logic [1:0] sz, input logic [63:0] d);
    int nbytes;
    nbytes = 1 << sz;
    if (nbytes == 8) return d;
    return d & ((64'd1 << (8 * nbytes)) - 64'd1);
  endfunction

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic drive_m(input bit m, input logic req, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [63:0] wd);
    if (m) begin m1_req = req; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd; end
    else   begin m0_req = req; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Step edges until master m of the chosen DUT acks, collecting bus activity.
  task automatic run_txn(input bit b, input bit m, input logic [31:0] ea, input logic [1:0] esz,
                         input logic [63:0] ewd, output int cyc, output logic [2:0] sel_seen,
                         output int sel_n, output int rd_n, output int wr_n, output bit other_ack,
                         output bit fields_ok, output logic err_v, output logic [63:0] rd_v,
                         output bit ok);
    logic [2:0] s;
    logic rd, wr;
    cyc = 0; sel_seen = 0; sel_n = 0; rd_n = 0; wr_n = 0; other_ack = 0; fields_ok = 1;
    err_v = 0; rd_v = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clock); #1;
      cyc++;
      s  = sel_of(b);
      rd = b ? b_mem_read : a_mem_read;
      wr = b ? b_mem_write_en : a_mem_write_en;
      if (s != 0) begin
        sel_n++;
        sel_seen |= s;
        if ((b ? b_mem_address : a_mem_address) != ea) fields_ok = 0;
        if ((b ? b_mem_size : a_mem_size) != esz) fields_ok = 0;
        if (wr && (b ? b_mem_wdata : a_mem_wdata) != ewd) fields_ok = 0;
      end
      if (rd) rd_n++;
      if (wr) wr_n++;
      if (ack_of(b, !m)) other_ack = 1;
      if (ack_of(b, m)) begin
        ok = 1; err_v = err_of(b, m); rd_v = rdata_of(b, m);
      end
    end
  endtask

  typedef struct {
    bit          m;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] rin;
    logic [63:0] exp_rd;
    logic        exp_err;
    logic [2:0]  exp_sel;
    int          exp_cyc;
  } vec_t;

  function automatic vec_t mk(input bit m, input logic we, input logic [1:0] sz,
                              input logic [31:0] a, input logic [63:0] rin,
                              input logic [63:0] exp_rd, input logic exp_err,
                              input logic [2:0] exp_sel);
    vec_t v;
    v.m = m; v.we = we; v.sz = sz; v.addr = a; v.wd = {a, ~a}; v.rin = rin;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_sel = exp_sel;
    v.exp_cyc = exp_err ? 1 : W_A + 1;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [10];
    edges = '{32'h0, 32'h3FF, 32'h400, 32'hFFF, 32'h1000, 32'h1FFF, 32'h2000,
              32'hFFFE_FFFF, 32'hFFFF_00FF, 32'hFFFF_0100};
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 32'h3FF));
      1: return 32'h1000 + 32'($urandom_range(0, 32'hFFF));
      2: return 32'hFFFF_0000 + 32'($urandom_range(0, 255));
      3: return 32'($urandom());
      default: return edges[$urandom_range(0, 9)];
    endcase
  endfunction

  vec_t        tbl [14];
  vec_t        v;
  int          cyc, sel_n, rd_n, wr_n, acks;
  logic [2:0]  sel_seen;
  bit          other_ack, fields_ok, ok;
  logic        err_v;
  logic [63:0] rd_v;

  // Reference model state for the randomized run.
  int          k, free_edge, gr_edge, ack_edge;
  bit          g, last, merr, mwe, in_acc, in_rom, in_ram, in_io;
  logic [1:0]  msz;
  logic [31:0] ma;
  logic [63:0] mwd, rd0, rd1;
  logic [2:0]  msel;

  initial begin
    tbl[0]  = mk(0, 0, 2'b11, 32'h0000_1008, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 0, 3'b010);
    tbl[1]  = mk(1, 0, 2'b00, 32'h0000_0010, 64'hDEAD_BEEF_0123_4567, 64'h67, 0, 3'b100);
    tbl[2]  = mk(0, 0, 2'b01, 32'hFFFF_00FE, 64'h1122_3344_5566_7788, 64'h7788, 0, 3'b001);
    tbl[3]  = mk(1, 0, 2'b10, 32'h0000_03FF, 64'hCAFE_F00D_8BAD_F00D, 64'h8BAD_F00D, 0, 3'b100);
    tbl[4]  = mk(0, 0, 2'b11, 32'h0000_0400, 64'h1, 64'h7788, 1, 3'b000);
    tbl[5]  = mk(0, 1, 2'b10, 32'h0000_0100, 64'h2, 64'h7788, 1, 3'b000);
    tbl[6]  = mk(1, 1, 2'b11, 32'h0000_1FF8, 64'h3, 64'h8BAD_F00D, 0, 3'b010);
    tbl[7]  = mk(1, 0, 2'b11, 32'h0000_2000, 64'h4, 64'h8BAD_F00D, 1, 3'b000);
    tbl[8]  = mk(0, 0, 2'b00, 32'h0000_0FFF, 64'h5, 64'h7788, 1, 3'b000);
    tbl[9]  = mk(1, 0, 2'b11, 32'hFFFF_0100, 64'h6, 64'h8BAD_F00D, 1, 3'b000);
    tbl[10] = mk(0, 0, 2'b10, 32'hFFFF_0000, 64'hAAAA_BBBB_CCCC_DDDD, 64'hCCCC_DDDD, 0, 3'b001);
    tbl[11] = mk(0, 1, 2'b00, 32'h0000_1000, 64'h7, 64'hCCCC_DDDD, 0, 3'b010);
    tbl[12] = mk(1, 0, 2'b01, 32'hFFFE_FFFF, 64'h8, 64'h8BAD_F00D, 1, 3'b000);
    tbl[13] = mk(0, 0, 2'b00, 32'h0000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 64'hDD, 0, 3'b100);
    mem_rdata = 0;

    // Reset state, checked while reset is still asserted.
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs_a", 64'(a_nz), 64'd0);
    chk("reset_outputs_b", 64'(b_nz), 64'd0);
    reset = 1'b1;

    // Directed vector table on the WAIT_CYC=1 instance.
    for (int i = 0; i < 14; i++) begin
      v = tbl[i];
      idle_inputs();
      mem_rdata = v.rin;
      drive_m(v.m, 1'b1, v.we, v.sz, v.addr, v.wd);
      run_txn(0, v.m, v.addr, v.sz, v.wd, cyc, sel_seen, sel_n, rd_n, wr_n, other_ack,
              fields_ok, err_v, rd_v, ok);
      chk($sformatf("vec%0d_ack_seen", i), 64'(ok), 64'd1);
      chk($sformatf("vec%0d_latency", i), 64'(cyc), 64'(v.exp_cyc));
      chk($sformatf("vec%0d_err", i), 64'(err_v), 64'(v.exp_err));
      chk($sformatf("vec%0d_rdata", i), rd_v, v.exp_rd);
      chk($sformatf("vec%0d_select", i), 64'(sel_seen), 64'(v.exp_sel));
      chk($sformatf("vec%0d_read_cycles", i), 64'(rd_n), 64'((!v.exp_err && !v.we) ? W_A : 0));
      chk($sformatf("vec%0d_write_cycles", i), 64'(wr_n), 64'((!v.exp_err && v.we) ? W_A : 0));
      chk($sformatf("vec%0d_other_ack", i), 64'(other_ack), 64'd0);
      chk($sformatf("vec%0d_bus_fields", i), 64'(fields_ok), 64'd1);
      drive_m(v.m, 1'b0, v.we, v.sz, v.addr, v.wd);
      @(posedge clock); #1;
      chk($sformatf("vec%0d_ack_one_cycle", i), 64'(ack_of(0, v.m)), 64'd0);
    end

    // Simultaneous requests: reset tie-break to m0, then m1, then a new tie goes to m0.
    do_reset();
    mem_rdata = 64'h0102_0304_0506_0708;
    drive_m(0, 1'b1, 1'b0, 2'b11, 32'h0000_1000, 64'd0);
    drive_m(1, 1'b1, 1'b0, 2'b10, 32'h0000_1010, 64'd0);
    run_txn(0, 0, 32'h0000_1000, 2'b11, 64'd0, cyc, sel_seen, sel_n, rd_n, wr_n, other_ack,
            fields_ok, err_v, rd_v, ok);
    chk("tie1_m0_first_latency", 64'(cyc), 64'd2);
    chk("tie1_m1_waits", 64'(other_ack), 64'd0);
    chk("tie1_m0_rdata", rd_v, 64'h0102_0304_0506_0708);
    m0_req = 1'b0;
    run_txn(0, 1, 32'h0000_1010, 2'b10, 64'd0, cyc, sel_seen, sel_n, rd_n, wr_n, other_ack,
            fields_ok, err_v, rd_v, ok);
    chk("tie1_m1_ack_spacing", 64'(cyc), 64'd3);
    chk("tie1_m1_rdata", rd_v, 64'h0506_0708);
    chk("tie1_m1_bus_fields", 64'(fields_ok), 64'd1);
    m0_req = 1'b1;
    run_txn(0, 0, 32'h0000_1000, 2'b11, 64'd0, cyc, sel_seen, sel_n, rd_n, wr_n, other_ack,
            fields_ok, err_v, rd_v, ok);
    chk("tie2_m0_wins_again", 64'(ok && !other_ack), 64'd1);
    chk("tie2_latency", 64'(cyc), 64'd3);
    idle_inputs();

    // Long write to IO on the WAIT_CYC=3 instance.
    do_reset();
    drive_m(1, 1'b1, 1'b1, 2'b11, 32'hFFFF_0004, 64'h0123_4567_89AB_CDEF);
    run_txn(1, 1, 32'hFFFF_0004, 2'b11, 64'h0123_4567_89AB_CDEF, cyc, sel_seen, sel_n, rd_n,
            wr_n, other_ack, fields_ok, err_v, rd_v, ok);
    chk("w3_io_latency", 64'(cyc), 64'd4);
    chk("w3_io_select", 64'(sel_seen), 64'b001);
    chk("w3_select_cycles", 64'(sel_n), 64'd3);
    chk("w3_write_cycles", 64'(wr_n), 64'd3);
    chk("w3_read_cycles", 64'(rd_n), 64'd0);
    chk("w3_wdata_addr", 64'(fields_ok), 64'd1);
    chk("w3_err", 64'(err_v), 64'd0);
    chk("w3_rdata_kept", rd_v, 64'd0);
    idle_inputs();

    // Reset in the middle of an ACCESS on the WAIT_CYC=3 instance.
    do_reset();
    mem_rdata = 64'h1111_2222_3333_4444;
    drive_m(0, 1'b1, 1'b0, 2'b10, 32'h0000_1800, 64'd0);
    repeat (2) begin @(posedge clock); #1; end
    chk("rst_mid_in_access", 64'(b_ram && b_mem_read), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_outputs_b", 64'(b_nz), 64'd0);
    chk("rst_mid_outputs_a", 64'(a_nz), 64'd0);
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (b_m0_ack || b_m1_ack || b_mem_read || b_ram) acks++;
    end
    chk("rst_mid_no_ack_after", 64'(acks), 64'd0);
    mem_rdata = 64'hFEDC_BA98_7654_3210;
    drive_m(0, 1'b1, 1'b0, 2'b10, 32'h0000_1800, 64'd0);
    run_txn(1, 0, 32'h0000_1800, 2'b10, 64'd0, cyc, sel_seen, sel_n, rd_n, wr_n, other_ack,
            fields_ok, err_v, rd_v, ok);
    chk("rst_fresh_latency", 64'(cyc), 64'd4);
    chk("rst_fresh_rdata", rd_v, 64'h7654_3210);
    chk("rst_fresh_select", 64'(sel_seen), 64'b010);
    chk("rst_fresh_read_cycles", 64'(rd_n), 64'd3);
    idle_inputs();

    // Randomized traffic on the WAIT_CYC=1 instance against the timing model.
    do_reset();
    free_edge = 0; gr_edge = -100; ack_edge = -100; last = 1; merr = 1; mwe = 0;
    msz = 0; ma = 0; mwd = 0; rd0 = 0; rd1 = 0; msel = 0; g = 0;
    for (k = 0; k < 2000; k++) begin
      m0_req = ($urandom_range(0, 9) < 6); m1_req = ($urandom_range(0, 9) < 6);
      m0_we = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
      m0_size = 2'($urandom_range(0, 3)); m1_size = 2'($urandom_range(0, 3));
      m0_addr = rand_addr(); m1_addr = rand_addr();
      m0_wdata = {$urandom(), $urandom()}; m1_wdata = {$urandom(), $urandom()};
      mem_rdata = {$urandom(), $urandom()};
      @(posedge clock); #1;
      if (k >= free_edge && (m0_req || m1_req)) begin
        g    = (m0_req && m1_req) ? !last : m1_req;
        last = g;
        ma   = g ? m1_addr : m0_addr;
        mwe  = g ? m1_we : m0_we;
        msz  = g ? m1_size : m0_size;
        mwd  = g ? m1_wdata : m0_wdata;
        in_rom = ma < ROM_LIMIT;
        in_ram = ma >= RAM_BASE && ma < RAM_LIMIT;
        in_io  = ma >= IO_BASE && ma < IO_LIMIT;
        merr = !(in_rom || in_ram || in_io) || (in_rom && mwe);
        msel = merr ? 3'b000 : {in_rom, in_ram, in_io};
        gr_edge   = k;
        ack_edge  = merr ? k : k + W_A;
        free_edge = ack_edge + 2;
      end
      in_acc = !merr && k >= gr_edge && k < gr_edge + W_A;
      if (k == ack_edge && !merr && !mwe) begin
        if (g) rd1 = ref_mask(msz, mem_rdata);
        else   rd0 = ref_mask(msz, mem_rdata);
      end
      chk("rnd_m0_ack", 64'(a_m0_ack), 64'(k == ack_edge && !g));
      chk("rnd_m1_ack", 64'(a_m1_ack), 64'(k == ack_edge && g));
      chk("rnd_m0_err", 64'(a_m0_err), 64'(k == ack_edge && !g && merr));
      chk("rnd_m1_err", 64'(a_m1_err), 64'(k == ack_edge && g && merr));
      chk("rnd_m0_rdata", a_m0_rdata, rd0);
      chk("rnd_m1_rdata", a_m1_rdata, rd1);
      chk("rnd_selects", 64'({a_rom, a_ram, a_io}), 64'(in_acc ? msel : 3'b000));
      chk("rnd_strobes", 64'({a_mem_read, a_mem_write_en}), 64'(in_acc ? {!mwe, mwe} : 2'b00));
      if (in_acc) chk("rnd_bus_fields", {a_mem_address, 30'd0, a_mem_size} ^ a_mem_wdata,
                      {ma, 30'd0, msz} ^ mwd);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
